// File: rtl/tick_blinker_pkg.sv
// ---------------------------------------------------------------------------
// tick_blinker_pkg
// Shared type for the tick blinker: the FSM state encoding.
//   IDLE : nothing in progress, LED dark
//   ON   : LED lit for a fixed number of cycles
//   GAP  : mandatory dark gap after every blink
// ---------------------------------------------------------------------------
package tick_blinker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/blink_timer.sv
// ---------------------------------------------------------------------------
// blink_timer
// Loadable down-counter with a zero flag, used to time ON and GAP phases.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset (count -> 0)
//   i_load     in   load i_load_val this cycle (has priority over i_en)
//   i_load_val in   W-bit value to load
//   i_en       in   decrement by one this cycle (stops at zero)
//   o_zero     out  1 when the current count is zero
// ---------------------------------------------------------------------------
module blink_timer #(
    parameter int W = 22
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - ONE;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/tick_blinker.sv
// ---------------------------------------------------------------------------
// tick_blinker
// Turns single-cycle event ticks into visible LED blinks: each event gives
// one ON pulse of 2^N_ON cycles followed by a dark gap of 2^N_OFF cycles.
// Events that arrive while a blink/gap is running are queued in a
// saturating pending counter (max 2^P-1); overflowing events are dropped.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   req_tick  in   single-cycle event request
//   led       out  1 = LED lit (state ON)
//   busy      out  1 whenever state != IDLE
//   pending   out  number of queued, not-yet-started blinks
//   dropped   out  one-cycle pulse when a request is lost to saturation
//   dbg_state out  current FSM state (state_t encoding) for observation
// Handshake: req_tick is a fire-and-forget single-cycle strobe; there is no
// ready. A request is either started, queued, or flagged on dropped in the
// same cycle it is presented.
// ---------------------------------------------------------------------------
module tick_blinker
    import tick_blinker_pkg::*;
#(
    parameter int N_ON  = 22,
    parameter int N_OFF = 22,
    parameter int P     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_tick,
    output logic         led,
    output logic         busy,
    output logic [P-1:0] pending,
    output logic         dropped,
    output logic [1:0]   dbg_state
);

    localparam int TW = (N_ON > N_OFF) ? N_ON : N_OFF;

    // Load values are all-ones of the phase width; the phase lasts
    // load+1 cycles because the state exits on the cycle the timer reads 0.
    localparam logic [TW-1:0] ON_LOAD  = TW'({N_ON{1'b1}});
    localparam logic [TW-1:0] OFF_LOAD = TW'({N_OFF{1'b1}});
    localparam logic [P-1:0]  P_MAX    = {P{1'b1}};
    localparam logic [P-1:0]  P_ONE    = P'(1);

    state_t         r_state;
    logic [P-1:0]   r_pending;

    logic           w_zero;
    logic           w_gap_end;
    logic           w_consume;
    logic           w_inc;
    logic           w_dec;
    logic           w_load;
    logic [TW-1:0]  w_load_val;
    logic           w_timer_en;

    // A GAP ending with work (queued or arriving right now) chains straight
    // into the next ON without visiting IDLE.
    assign w_gap_end = (r_state == GAP) && w_zero;
    assign w_consume = w_gap_end && ((r_pending != '0) || req_tick);

    // A request arriving together with a consume cancels the decrement:
    // either it is the event being started, or it refills the freed slot.
    assign w_inc = req_tick && (r_state != IDLE);
    assign w_dec = w_consume;

    assign w_timer_en = (r_state == ON) || (r_state == GAP);

    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            IDLE: begin
                if (req_tick) begin
                    w_load     = 1'b1;
                    w_load_val = ON_LOAD;
                end
            end
            ON: begin
                if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = OFF_LOAD;
                end
            end
            GAP: begin
                if (w_consume) begin
                    w_load     = 1'b1;
                    w_load_val = ON_LOAD;
                end
            end
            default: begin
                w_load     = 1'b0;
                w_load_val = '0;
            end
        endcase
    end

    blink_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_timer_en),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_tick) begin
                        r_state <= ON;
                    end
                end
                ON: begin
                    if (w_zero) begin
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (w_consume) begin
                        r_state <= ON;
                    end else if (w_zero) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            case ({w_inc, w_dec})
                2'b10: begin
                    if (r_pending != P_MAX) begin
                        r_pending <= r_pending + P_ONE;
                    end
                end
                2'b01: begin
                    r_pending <= r_pending - P_ONE;
                end
                default: begin
                    r_pending <= r_pending;
                end
            endcase
        end
    end

    assign led       = (r_state == ON);
    assign busy      = (r_state != IDLE);
    assign pending   = r_pending;
    assign dropped   = w_inc && !w_dec && (r_pending == P_MAX);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_tick_blinker.sv
// ---------------------------------------------------------------------------
// tb_tick_blinker
// Table-driven scenarios (tick pattern plus hand-derived expected blink
// start cycles, drop cycle, idle cycle and pending checkpoints) with a
// scoreboard queue of expected blink start cycles, plus a hand-written
// mid-blink reset sequence. N_ON=3 (8 cycles), N_OFF=2 (4 cycles), P=2.
// Cycle c = clock period that begins at the c-th posedge after reset
// release; inputs are driven #1 after that edge, outputs sampled at the
// following negedge.
// ---------------------------------------------------------------------------
module tb_tick_blinker;
    import tick_blinker_pkg::*;

    localparam int N_ON   = 3;
    localparam int N_OFF  = 2;
    localparam int P      = 2;
    localparam int ON_LEN = 8;
    localparam int NVEC   = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_tick;
    logic         led;
    logic         busy;
    logic [P-1:0] pending;
    logic         dropped;
    logic [1:0]   dbg_state;

    tick_blinker #(
        .N_ON  (N_ON),
        .N_OFF (N_OFF),
        .P     (P)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_tick  (req_tick),
        .led       (led),
        .busy      (busy),
        .pending   (pending),
        .dropped   (dropped),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [127:0] tick_mask;
        logic [127:0] start_mask;
        int           drop_cycle;
        int           idle_cycle;
        int           chk_cycle;
        int           chk_pending;
        int           max_pending;
        int           len;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic logic [127:0] bit_at(input int a);
        logic [127:0] one;
        one = 128'd1;
        return one << a;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n    = 1'b0;
        req_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset led",     int'(led),       0);
        check("reset busy",    int'(busy),      0);
        check("reset pending", int'(pending),   0);
        check("reset dropped", int'(dropped),   0);
        check("reset state",   int'(dbg_state), int'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   first_start;
        int   max_seen;
        int   exp_c;
        logic prev_led;
        logic exp_led;
        logic exp_busy;

        first_start = -1;
        for (int b = 0; b < 128; b++) begin
            if (v.start_mask[b]) begin
                exp_q.push_back(8'(b));
                if (first_start < 0) first_start = b;
            end
        end
        max_seen = 0;
        prev_led = 1'b0;

        for (int c = 0; c < v.len; c++) begin
            @(posedge clk);
            #1 req_tick = v.tick_mask[c];
            @(negedge clk);

            exp_led = 1'b0;
            for (int k = 0; k < ON_LEN; k++) begin
                if ((c - k) >= 0 && v.start_mask[c - k]) exp_led = 1'b1;
            end
            exp_busy = (c >= first_start) && (c < v.idle_cycle);

            check($sformatf("v%0d led c%0d", idx, c), int'(led), int'(exp_led));
            check($sformatf("v%0d busy c%0d", idx, c), int'(busy), int'(exp_busy));
            check($sformatf("v%0d dropped c%0d", idx, c), int'(dropped),
                  (c == v.drop_cycle) ? 1 : 0);

            if (led && !prev_led) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL v%0d blink start: unexpected blink at cycle %0d, none expected", idx, c);
                end else begin
                    exp_c = int'(exp_q.pop_front());
                    check($sformatf("v%0d blink start", idx), c, exp_c);
                end
            end
            prev_led = led;

            if (int'(pending) > max_seen) max_seen = int'(pending);
            if (c == v.chk_cycle)
                check($sformatf("v%0d pending c%0d", idx, c), int'(pending), v.chk_pending);
        end
        req_tick = 1'b0;

        check($sformatf("v%0d max pending", idx), max_seen, v.max_pending);
        check($sformatf("v%0d missing blinks", idx), exp_q.size(), 0);
        check($sformatf("v%0d end pending", idx), int'(pending), 0);
        check($sformatf("v%0d end state", idx), int'(dbg_state), int'(IDLE));
        exp_q.delete();
    endtask

    // ---------------- test ----------------
    initial begin
        int bad;
        logic [127:0] rmask;

        // single tick
        vecs[0] = '{tick_mask: bit_at(10), start_mask: bit_at(11),
                    drop_cycle: -1, idle_cycle: 23, chk_cycle: 15, chk_pending: 0,
                    max_pending: 0, len: 30};
        // three spaced ticks: queue 1, 2 then drain
        vecs[1] = '{tick_mask: bit_at(10) | bit_at(12) | bit_at(14),
                    start_mask: bit_at(11) | bit_at(23) | bit_at(35),
                    drop_cycle: -1, idle_cycle: 47, chk_cycle: 15, chk_pending: 2,
                    max_pending: 2, len: 55};
        // five ticks during the first blink: saturate, fifth dropped
        vecs[2] = '{tick_mask: bit_at(10) | bit_at(12) | bit_at(13) | bit_at(14) | bit_at(15),
                    start_mask: bit_at(11) | bit_at(23) | bit_at(35) | bit_at(47),
                    drop_cycle: 15, idle_cycle: 59, chk_cycle: 16, chk_pending: 3,
                    max_pending: 3, len: 65};
        // saturated queue, tick on GAP-exit cycle: no drop, pending holds
        vecs[3] = '{tick_mask: bit_at(10) | bit_at(12) | bit_at(13) | bit_at(14) | bit_at(22),
                    start_mask: bit_at(11) | bit_at(23) | bit_at(35) | bit_at(47) | bit_at(59),
                    drop_cycle: -1, idle_cycle: 71, chk_cycle: 23, chk_pending: 3,
                    max_pending: 3, len: 78};
        // tick on GAP-exit cycle with empty queue: chain without IDLE
        vecs[4] = '{tick_mask: bit_at(10) | bit_at(22),
                    start_mask: bit_at(11) | bit_at(23),
                    drop_cycle: -1, idle_cycle: 35, chk_cycle: 22, chk_pending: 0,
                    max_pending: 0, len: 42};

        for (int i = 0; i < NVEC; i++) begin
            do_reset();
            run_vec(i, vecs[i]);
        end

        // mid-blink reset: blink starts at cycle 11, pending reaches 2 by
        // cycle 14, reset asserted inside cycle 15 (5th ON cycle)
        do_reset();
        rmask = bit_at(10) | bit_at(12) | bit_at(13);
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1 req_tick = rmask[c];
            @(negedge clk);
        end
        req_tick = 1'b0;
        check("pre-reset led",     int'(led),     1);
        check("pre-reset pending", int'(pending), 2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async reset led",     int'(led),     0);
        check("async reset busy",    int'(busy),    0);
        check("async reset pending", int'(pending), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (led || busy || (pending != '0) || dropped) bad++;
        end
        check("post-reset quiet cycles with activity", bad, 0);
        check("post-reset state", int'(dbg_state), int'(IDLE));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
